// File: rtl/riscv_fetch_ctrl_pkg.sv
// Shared fetch-stage types: FSM state encoding and next-pc source select.
package riscv_constants;

    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD,
        FETCH_DROP,
        FETCH_HALT
    } fetch_state_e;

    typedef enum logic [2:0] {
        PC_SEL_HOLD,
        PC_SEL_SEQ,
        PC_SEL_REDIRECT,
        PC_SEL_TRAP,
        PC_SEL_MRET,
        PC_SEL_HALT
    } pc_sel_e;

    localparam int unsigned INST_BYTES = 4;

    // Any source other than hold/sequential throws away in-flight fetch work.
    function automatic logic is_flush(input pc_sel_e sel);
        return (sel != PC_SEL_HOLD) && (sel != PC_SEL_SEQ);
    endfunction

endpackage

// File: rtl/riscv_fetch_next_pc.sv
// Combinational next-pc priority select: ecall > mret > redirect > sequential.
// RISCV_FETCH_TRAP_EN enables trap vectoring and mret; otherwise ecall requests a halt.
module riscv_fetch_next_pc
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   ecall,
    input  logic                   mret,
    input  logic                   redirect_valid,
    input  logic                   seq_adv,
    input  logic [WORD_LENGTH-1:0] redirect_addr,
    input  logic [WORD_LENGTH-1:0] mtvec_addr,
    input  logic [WORD_LENGTH-1:0] mepc,
    input  logic [WORD_LENGTH-1:0] pc,
    output pc_sel_e                pc_sel,
    output logic [WORD_LENGTH-1:0] next_pc
);

    logic trap_hit;
    logic mret_hit;
    logic halt_hit;

`ifdef RISCV_FETCH_TRAP_EN
    assign trap_hit = ecall;
    assign mret_hit = mret;
    assign halt_hit = 1'b0;
`else
    logic unused_mret;
    assign unused_mret = mret;
    assign trap_hit    = 1'b0;
    assign mret_hit    = 1'b0;
    assign halt_hit    = ecall;
`endif

    always_comb begin
        pc_sel  = PC_SEL_HOLD;
        next_pc = pc;
        if (halt_hit) begin
            pc_sel = PC_SEL_HALT;
        end else if (trap_hit) begin
            pc_sel  = PC_SEL_TRAP;
            next_pc = mtvec_addr;
        end else if (mret_hit) begin
            pc_sel  = PC_SEL_MRET;
            next_pc = mepc;
        end else if (redirect_valid) begin
            pc_sel  = PC_SEL_REDIRECT;
            next_pc = redirect_addr;
        end else if (seq_adv) begin
            pc_sel  = PC_SEL_SEQ;
            next_pc = pc + WORD_LENGTH'(INST_BYTES);
        end
    end

endmodule

// File: rtl/riscv_fetch_ctrl.sv
// Instruction fetch controller: single-outstanding imem requests, valid/ready to decode, flushes.
// Trap handling (ecall/mret vectoring) is built only with RISCV_FETCH_TRAP_EN defined.
module riscv_fetch_ctrl
    import riscv_constants::*;
#(
    parameter int                     WORD_LENGTH  = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   x_reset,
    output logic                   imem_req,
    output logic [WORD_LENGTH-1:0] imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [WORD_LENGTH-1:0] imem_rdata,
    output logic                   inst_valid,
    output logic [WORD_LENGTH-1:0] inst,
    output logic [WORD_LENGTH-1:0] inst_pc,
    input  logic                   inst_ready,
    input  logic                   redirect_valid,
    input  logic [WORD_LENGTH-1:0] redirect_addr,
    input  logic                   ecall,
    input  logic [WORD_LENGTH-1:0] ecall_pc,
    input  logic [WORD_LENGTH-1:0] mtvec_addr,
    input  logic                   mret,
    output logic [WORD_LENGTH-1:0] mepc_out,
    output logic                   halted
);

    fetch_state_e           state_q, state_d;
    logic [WORD_LENGTH-1:0] pc_q, pc_d;
    logic [WORD_LENGTH-1:0] inst_q, inst_d;
    logic [WORD_LENGTH-1:0] inst_pc_q, inst_pc_d;
    logic                   inst_valid_q, inst_valid_d;
    logic [WORD_LENGTH-1:0] mepc_q, mepc_d;
    logic                   halted_q, halted_d;

    pc_sel_e                pc_sel;
    logic [WORD_LENGTH-1:0] next_pc;
    logic                   active;
    logic                   flush;
    logic                   pending;

    riscv_fetch_next_pc #(.WORD_LENGTH(WORD_LENGTH)) u_next_pc (
        .ecall          (ecall),
        .mret           (mret),
        .redirect_valid (redirect_valid),
        .seq_adv        ((state_q == FETCH_WAIT) && imem_rvalid),
        .redirect_addr  (redirect_addr),
        .mtvec_addr     (mtvec_addr),
        .mepc           (mepc_q),
        .pc             (pc_q),
        .pc_sel         (pc_sel),
        .next_pc        (next_pc)
    );

    // Flush sources are only honoured once fetching has started and before a halt.
    assign active = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT) ||
                    (state_q == FETCH_HOLD) || (state_q == FETCH_DROP);
    assign flush  = active && is_flush(pc_sel);

    // A granted-but-unanswered request must have its response swallowed.
    assign pending = ((state_q == FETCH_REQ) && imem_gnt) ||
                     (((state_q == FETCH_WAIT) || (state_q == FETCH_DROP)) && !imem_rvalid);

    always_comb begin
        state_d      = state_q;
        pc_d         = active ? next_pc : pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        mepc_d       = mepc_q;
        halted_d     = halted_q;

        case (state_q)
            FETCH_IDLE: state_d = FETCH_REQ;
            FETCH_REQ:  if (imem_gnt) state_d = FETCH_WAIT;
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = FETCH_REQ;
                end
            end
            FETCH_DROP: if (imem_rvalid) state_d = FETCH_REQ;
            default:    state_d = state_q;
        endcase

        if (flush) begin
            inst_d       = inst_q;
            inst_pc_d    = inst_pc_q;
            inst_valid_d = 1'b0;
            state_d      = pending ? FETCH_DROP : FETCH_REQ;
            if (pc_sel == PC_SEL_TRAP) mepc_d = ecall_pc;
            if (pc_sel == PC_SEL_HALT) begin
                state_d  = FETCH_HALT;
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            state_q      <= FETCH_IDLE;
            pc_q         <= RESET_VECTOR;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            mepc_q       <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            mepc_q       <= mepc_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_req   = (state_q == FETCH_REQ);
    assign imem_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign mepc_out   = mepc_q;
    assign halted     = halted_q;

endmodule
